// File: rtl/frame_reader.sv
// frame_reader: fetches a WIDTH x HEIGHT frame one 32-bit word per bus read
// and streams it out through a single-entry valid/ready slot with frame markers.
module frame_reader #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [18:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bus_read,
    output logic [18:0] bus_read_addr,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        o_sof,
    output logic        o_eol,
    output logic        o_eof
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, FLUSH} state_t;

    state_t        state, state_nx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [TW-1:0] tcnt;
    logic          accept, capture, expire, x_last, y_last;

    assign accept   = o_valid && o_ready;
    assign capture  = state == WAIT && bus_rvalid;
    assign expire   = state == WAIT && !bus_rvalid && tcnt == TW'(TIMEOUT - 1);
    assign x_last   = x == XW'(WIDTH - 1);
    assign y_last   = y == YW'(HEIGHT - 1);
    assign busy     = state != IDLE;
    assign bus_read = state == REQ || state == WAIT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // A new read starts only once the output slot is free or draining this cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? REQ : IDLE;
            REQ:     state_nx = WAIT;
            WAIT:    state_nx = capture ? (x_last && y_last ? FLUSH : GAP) : expire ? IDLE : WAIT;
            GAP:     state_nx = (!o_valid || accept) ? REQ : GAP;
            FLUSH:   state_nx = accept ? IDLE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_read_addr <= '0;
            x             <= '0;
            y             <= '0;
            tcnt          <= '0;
            err           <= 1'b0;
            done          <= 1'b0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_sof         <= 1'b0;
            o_eol         <= 1'b0;
            o_eof         <= 1'b0;
        end else begin
            done    <= state == FLUSH && accept;
            tcnt    <= state == WAIT ? tcnt + TW'(1) : '0;
            o_valid <= capture ? 1'b1 : (expire || o_ready) ? 1'b0 : o_valid;
            if (state == IDLE && start) begin
                bus_read_addr <= base_addr;
                err           <= 1'b0;
                x             <= '0;
                y             <= '0;
            end
            if (expire) err <= 1'b1;
            // Markers describe the word being captured, so they use the pre-increment position
            if (capture) begin
                o_data        <= bus_rdata;
                o_sof         <= x == '0 && y == '0;
                o_eol         <= x_last;
                o_eof         <= x_last && y_last;
                bus_read_addr <= bus_read_addr + 19'd4;
                x             <= x_last ? '0 : x + XW'(1);
                if (x_last) y <= y_last ? '0 : y + YW'(1);
            end
        end
    end
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: randomized frames against a queue-based reference of expected reads and pixels.
module tb_frame_reader;
    localparam int WIDTH = 4, HEIGHT = 2, TIMEOUT = 15, NPX = WIDTH * HEIGHT;

    logic        clk = 0, reset_n = 1, start = 0;
    logic [18:0] base_addr = '0;
    logic        busy, done, err, bus_read;
    logic [18:0] bus_read_addr;
    logic [31:0] bus_rdata, o_data;
    logic        bus_rvalid, o_valid, o_ready, o_sof, o_eol, o_eof;

    frame_reader #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .err(err), .bus_read(bus_read), .bus_read_addr(bus_read_addr),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .o_data(o_data), .o_valid(o_valid),
        .o_ready(o_ready), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_pass = 0;
    int          req_n = 0, drop_rd = -1, rmode = 2, done_cnt = 0, last_run = 0;
    bit          fixed_lat = 1;
    logic [18:0] exp_rd[$];
    logic [34:0] exp_px[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] dexp(input logic [18:0] a);
        return {13'd0, a} ^ 32'hC0DE_0000;
    endfunction

    // Bus responder and o_ready driver; stray rvalid pulses while no read is pending
    initial begin
        int cnt, lat;
        cnt = 0; lat = 3;
        bus_rvalid = 0; bus_rdata = 0; o_ready = 0;
        forever begin
            @(negedge clk);
            o_ready = rmode == 2 ? 1'b1 : rmode == 1 ? 1'b0 : ($urandom % 4 != 0);
            if (bus_read) begin
                if (cnt == 0) begin
                    req_n++;
                    lat = fixed_lat ? 3 : int'($urandom_range(2, 6));
                end
                cnt++;
            end else cnt = 0;
            bus_rvalid = 0;
            bus_rdata  = $urandom;
            if (bus_read && cnt == lat && req_n - 1 != drop_rd) begin
                bus_rvalid = 1;
                bus_rdata  = dexp(bus_read_addr);
            end else if (!bus_read && $urandom % 4 == 0) bus_rvalid = 1;
        end
    end

    // Monitor: read addresses, slot hold, accepted pixels, done pulses
    initial begin
        bit pb, pv, pr;
        logic [34:0] pd, cur;
        int run;
        pb = 0; pv = 0; pr = 0; pd = '0; run = 0;
        forever begin
            @(negedge clk);
            #1;
            cur = {o_data, o_sof, o_eol, o_eof};
            if (!reset_n) begin
                pb = 0; pv = 0; pr = 0; run = 0;
            end else begin
                if (bus_read && !pb) begin
                    if (exp_rd.size() == 0) chk("extra_rd", 1, 0);
                    else chk("rd_addr", bus_read_addr, exp_rd.pop_front());
                end
                if (bus_read) begin
                    chk("rd_slot_empty", o_valid, 0);
                    run++;
                end else begin
                    if (pb) last_run = run;
                    run = 0;
                end
                if (pv && !pr) begin
                    chk("hold_valid", o_valid, 1);
                    chk("hold_data", cur, pd);
                end
                if (o_valid && o_ready) begin
                    if (exp_px.size() == 0) chk("extra_px", 1, 0);
                    else chk("pixel", cur, exp_px.pop_front());
                end
                if (done) done_cnt++;
                pb = bus_read; pv = o_valid; pr = o_ready; pd = cur;
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk(tag, {busy, done, err, bus_read, bus_read_addr, o_valid, o_data, o_sof, o_eol, o_eof}, 64'd0);
    endtask

    task automatic run_frame(input logic [18:0] b, input int drop, input bit stall, input int rst_at);
        int  n_px, stall_cyc;
        bit  fin;
        logic [18:0] a;
        exp_rd.delete();
        exp_px.delete();
        n_px = drop >= 0 ? drop : NPX;
        for (int k = 0; k < NPX; k++) begin
            a = b + 19'(4 * k);
            if (drop < 0 || k <= drop) exp_rd.push_back(a);
            if (k < n_px) exp_px.push_back({dexp(a), k == 0, (k % WIDTH) == WIDTH - 1, k == NPX - 1});
        end
        done_cnt = 0; req_n = 0; drop_rd = drop; stall_cyc = 0; fin = 0;
        if (stall) rmode = 1;
        start = 1; base_addr = b;
        @(negedge clk);
        start = 0;
        chk("start_busy", busy, 1);
        chk("start_err_clr", err, 0);
        chk("start_rd", bus_read, 1);
        for (int i = 0; i < 4000 && !fin; i++) begin
            @(negedge clk);
            if (rst_at > 0 && req_n >= rst_at) begin
                @(posedge clk);
                #1 reset_n = 0;
                #1 chk_reset_vals("rst_mid");
                exp_rd.delete();
                exp_px.delete();
                @(negedge clk);
                chk("rst_rd_low", bus_read, 0);
                @(negedge clk);
                reset_n = 1;
                repeat (3) @(negedge clk);
                chk("rst_no_done", done_cnt, 0);
                chk("rst_idle", busy, 0);
                return;
            end
            if (stall && o_valid && stall_cyc < 10) begin
                stall_cyc++;
                if (stall_cyc == 10) begin
                    chk("stall_one_read", req_n, 1);
                    rmode = 2;
                end
            end
            start = busy && ($urandom % 6 == 0);
            if (start) base_addr = $urandom;
            fin = !busy;
        end
        start = 0;
        chk("frame_bound", fin, 1);
        repeat (2) @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_done_cnt", done_cnt, drop < 0 ? 1 : 0);
        chk("end_err", err, drop >= 0);
        chk("end_px_left", exp_px.size(), 0);
        chk("end_rd_left", exp_rd.size(), 0);
        if (drop >= 0) chk("timeout_len", last_run >= TIMEOUT && last_run <= TIMEOUT + 2, 1);
        drop_rd = -1;
    endtask

    initial begin
        #3 reset_n = 0;
        #1 chk_reset_vals("rst_initial");
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk_reset_vals("idle_after_rst");
        rmode = 2; fixed_lat = 1;
        run_frame(19'h00100, -1, 0, 0);
        fixed_lat = 0;
        run_frame(19'h00200, -1, 1, 0);
        rmode = 0;
        run_frame(19'h7FFF8, -1, 0, 0);
        run_frame(19'($urandom) & 19'h7FFFC, 2, 0, 0);
        run_frame(19'($urandom) & 19'h7FFFC, -1, 0, 0);
        run_frame(19'h01000, -1, 0, 5);
        run_frame(19'h02340, -1, 0, 0);
        for (int f = 0; f < 4; f++) run_frame(19'($urandom) & 19'h7FFFC, -1, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
